poly_tone_gen: RTL and testbench

//  Polyphonic successor to the single-voice keyboard melody generator: NUM_CH square-wave voices driven by
//  PS/2 make codes, each voice with a timed note-hold and octave shift, mixed to one PWM speaker pin.

---
 rtl/tone_pkg.sv | 43 ++++
 rtl/tone_voice.sv | 83 ++++++++
 rtl/poly_tone_gen.sv | 140 ++++++++++++++
 tb/tb_poly_tone_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, octave-shift encodings and note table for poly_tone_gen
package tone_pkg;

  typedef enum logic {V_IDLE, V_PLAY} voice_state_t;

  localparam logic [1:0] OCT_NONE  = 2'd0;
  localparam logic [1:0] OCT_UP1   = 2'd1;
  localparam logic [1:0] OCT_UP2   = 2'd2;
  localparam logic [1:0] OCT_DOWN1 = 2'd3;

  localparam int NOTE_W = 11;

  // PS/2 make code -> half-period in voice ticks; 0 marks a code that is not a note key
  function automatic logic [NOTE_W-1:0] note_half(input logic [7:0] code);
    logic [NOTE_W-1:0] h;
    case (code)
      8'h15:   h = 11'd1911;
      8'h1D:   h = 11'd1703;
      8'h24:   h = 11'd1517;
      8'h2D:   h = 11'd1432;
      8'h2C:   h = 11'd1276;
      8'h35:   h = 11'd1136;
      8'h3C:   h = 11'd1012;
      8'h1C:   h = 11'd956;
      8'h1B:   h = 11'd851;
      8'h23:   h = 11'd758;
      8'h2B:   h = 11'd716;
      8'h34:   h = 11'd638;
      8'h33:   h = 11'd568;
      8'h3B:   h = 11'd506;
      8'h1A:   h = 11'd478;
      8'h22:   h = 11'd426;
      8'h21:   h = 11'd379;
      8'h2A:   h = 11'd358;
      8'h32:   h = 11'd319;
      8'h31:   h = 11'd284;
      8'h3A:   h = 11'd253;
      default: h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave voice: play/idle FSM, phase accumulator, ms hold timer
module tone_voice
  import tone_pkg::*;
#(
  parameter int DIV_W   = 13,
  parameter int HOLD_MS = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ms_tick,
  input  logic             start,
  input  logic             retrig,
  input  logic [DIV_W-1:0] half_in,
  input  logic [7:0]       code_in,
  output logic             active,
  output logic             square,
  output logic [7:0]       code_out
);

  localparam logic [11:0] HOLD_INIT = 12'(HOLD_MS);

  voice_state_t     state_q, state_d;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] phase_q;
  logic [11:0]      hold_q;
  logic             square_q;
  logic [7:0]       code_q;
  logic             expire;

  assign expire = (state_q == V_PLAY) && ms_tick && (hold_q == 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= V_IDLE;
    else        state_q <= state_d;
  end

  // A start or retrigger landing on the expiry cycle keeps the voice alive
  always_comb begin
    state_d = state_q;
    case (state_q)
      V_IDLE:  if (start) state_d = V_PLAY;
      V_PLAY:  if (!start && !retrig && expire) state_d = V_IDLE;
      default: state_d = V_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q   <= '0;
      phase_q  <= '0;
      hold_q   <= '0;
      square_q <= 1'b0;
      code_q   <= '0;
    end else if (start) begin
      half_q   <= half_in;
      phase_q  <= '0;
      hold_q   <= HOLD_INIT;
      square_q <= 1'b0;
      code_q   <= code_in;
    end else if (state_q == V_PLAY) begin
      if (tick) begin
        if (phase_q == half_q - DIV_W'(1)) begin
          phase_q  <= '0;
          square_q <= ~square_q;
        end else begin
          phase_q <= phase_q + DIV_W'(1);
        end
      end
      if (retrig)       hold_q <= HOLD_INIT;
      else if (ms_tick) hold_q <= hold_q - 12'd1;
      if (expire && !retrig) begin
        phase_q  <= '0;
        square_q <= 1'b0;
      end
    end
  end

  assign active   = (state_q == V_PLAY);
  assign square   = square_q;
  assign code_out = code_q;

endmodule

// File: rtl/poly_tone_gen.sv
// rtl/poly_tone_gen.sv - polyphonic PS/2 tone generator: timebase, voice allocator, PWM mixer
module poly_tone_gen
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000_000,
  parameter int NUM_CH  = 4,
  parameter int HOLD_MS = 500,
  parameter int DIV_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        code,
  input  logic              code_valid,
  input  logic [1:0]        octave_shift,
  input  logic              mute,
  output logic              speaker,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int PRE   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(PRE);
  localparam int SUM_W = $clog2(NUM_CH + 1);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [9:0]       ms_cnt;
  logic             tick, ms_tick;

  assign tick    = (pre_cnt == PRE_W'(PRE - 1));
  assign ms_tick = tick && (ms_cnt == 10'd999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) ms_cnt <= ms_tick ? 10'd0 : ms_cnt + 10'd1;
    end
  end

  logic [DIV_W-1:0]  half_base, half_sel;
  logic              note_ok;
  logic [NUM_CH-1:0] play, sq, start_v, retrig_v;
  logic [7:0]        v_code [NUM_CH];
  logic              hit, free_found, steal;
  logic [PTR_W-1:0]  steal_ptr;

  always_comb begin
    half_base = DIV_W'(note_half(code));
    half_sel  = half_base;
    case (octave_shift)
      OCT_NONE:  half_sel = half_base;
      OCT_UP1:   half_sel = half_base >> 1;
      OCT_UP2:   half_sel = half_base >> 2;
      OCT_DOWN1: half_sel = half_base << 1;
      default:   half_sel = half_base;
    endcase
  end

  assign note_ok = code_valid && (half_base != '0);

  // Priority: retrigger a voice already playing this code, else lowest idle voice, else steal
  always_comb begin
    retrig_v   = '0;
    start_v    = '0;
    hit        = 1'b0;
    free_found = 1'b0;
    steal      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && play[i] && (v_code[i] == code)) begin
        hit         = 1'b1;
        retrig_v[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && !free_found && !play[i]) begin
        free_found = 1'b1;
        start_v[i] = 1'b1;
      end
    end
    if (!hit && !free_found) begin
      steal = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (steal_ptr == PTR_W'(i)) start_v[i] = 1'b1;
      end
    end
    if (!note_ok) begin
      retrig_v = '0;
      start_v  = '0;
      steal    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     steal_ptr <= '0;
    else if (steal) steal_ptr <= (steal_ptr == PTR_W'(NUM_CH - 1)) ? '0 : steal_ptr + PTR_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
    tone_voice #(
      .DIV_W   (DIV_W),
      .HOLD_MS (HOLD_MS)
    ) u_voice (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .ms_tick  (ms_tick),
      .start    (start_v[i]),
      .retrig   (retrig_v[i]),
      .half_in  (half_sel),
      .code_in  (code),
      .active   (play[i]),
      .square   (sq[i]),
      .code_out (v_code[i])
    );
  end

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] pwm_cnt;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) sum = sum + SUM_W'(play[i] && sq[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      speaker <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == SUM_W'(NUM_CH - 1)) ? '0 : pwm_cnt + SUM_W'(1);
      speaker <= !mute && (pwm_cnt < sum);
    end
  end

  assign ch_active = play;

endmodule

// File: tb/tb_poly_tone_gen.sv
// tb/tb_poly_tone_gen.sv - scoreboard bench for poly_tone_gen (HOLD_MS=2, 2 clocks per tick)
module tb_poly_tone_gen;

  localparam int PRE    = 2;
  localparam int NUM_CH = 4;
  localparam int MS_CLK = 1000 * PRE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        code = 8'h00;
  logic              code_valid = 1'b0;
  logic [1:0]        octave_shift = 2'd0;
  logic              mute = 1'b0;
  logic              speaker;
  logic [NUM_CH-1:0] ch_active;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  poly_tone_gen #(
    .CLK_HZ  (2_000_000),
    .TICK_HZ (1_000_000),
    .NUM_CH  (NUM_CH),
    .HOLD_MS (2),
    .DIV_W   (13)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code         (code),
    .code_valid   (code_valid),
    .octave_shift (octave_shift),
    .mute         (mute),
    .speaker      (speaker),
    .ch_active    (ch_active)
  );

  wire [3:0] sq_probe = {dut.g_voice[3].u_voice.square_q, dut.g_voice[2].u_voice.square_q,
                         dut.g_voice[1].u_voice.square_q, dut.g_voice[0].u_voice.square_q};
  wire       sq0 = dut.g_voice[0].u_voice.square_q;

  int pm;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pm <= 0;
    else        pm <= (pm == NUM_CH - 1) ? 0 : pm + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic do_reset();
    code_valid   = 1'b0;
    mute         = 1'b0;
    octave_shift = 2'd0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] c, input logic [1:0] sh);
    @(negedge clk);
    code = c; octave_shift = sh; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  // Clocks between two rising edges of voice 0's square, retriggering every 1000 clocks
  task automatic measure_period(input logic [7:0] c, input logic [1:0] sh, output int period);
    int   r1;
    logic prev;
    period = -1;
    r1     = -1;
    prev   = sq0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      code = c; octave_shift = sh; code_valid = (cyc % 1000 == 999);
      if (!prev && sq0) begin
        if (r1 < 0) r1 = cyc;
        else begin
          period = cyc - r1;
          break;
        end
      end
      prev = sq0;
    end
    code_valid = 1'b0;
  endtask

  task automatic cycles_until_idle(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (!ch_active[0]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ms_tick(output int ok);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (dut.ms_tick) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_window(input int len, input logic m, output int sp_hi, output int both_hi,
                            output int bad);
    logic exp_sp;
    int   have;
    sp_hi = 0; both_hi = 0; bad = 0; have = 0; exp_sp = 1'b0;
    mute  = m;
    for (int cyc = 0; cyc < len; cyc++) begin
      @(negedge clk);
      code_valid = 1'b0;
      if (cyc % 1000 == 998) begin code = 8'h15; code_valid = 1'b1; end
      if (cyc % 1000 == 999) begin code = 8'h1D; code_valid = 1'b1; end
      if (have != 0 && speaker !== exp_sp) bad++;
      if (speaker) sp_hi++;
      if (sq_probe[1:0] == 2'b11 && ch_active[1:0] == 2'b11) both_hi++;
      exp_sp = !mute && (pm < $countones(sq_probe & ch_active));
      have   = 1;
    end
    code_valid = 1'b0;
  endtask

  logic [7:0] fill_codes [4];
  int         p, n, ok, sp_hi, both_hi, bad;

  initial begin
    fill_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D};

    do_reset();
    @(negedge clk);
    check("rst_speaker", speaker, 0);
    check("rst_ch_active", ch_active, 0);
    check("rst_steal_ptr", dut.steal_ptr, 0);

    // single note, shift 0
    sb_push("t1_active", 4'b0001);
    sb_push("t1_half", 1911);
    strobe(8'h15, 2'd0);
    sb_pop(ch_active);
    sb_pop(dut.g_voice[0].u_voice.half_q);
    sb_push("t1_period_clk", 2 * 1911 * PRE);
    measure_period(8'h15, 2'd0, p);
    sb_pop(p);

    // expiry after two ms_ticks with no retrigger
    do_reset();
    sb_push("t1_expire_window", 1);
    sb_push("t1_expire_square", 0);
    strobe(8'h15, 2'd0);
    cycles_until_idle(6000, n);
    sb_pop(int'(n >= 3 * MS_CLK / 2 && n <= 5 * MS_CLK / 2));
    sb_pop(sq0);

    // octave shifts
    do_reset();
    sb_push("t2_up1_half", 478);
    sb_push("t2_up1_period_clk", 2 * 478 * PRE);
    strobe(8'h1C, 2'd1);
    sb_pop(dut.g_voice[0].u_voice.half_q);
    measure_period(8'h1C, 2'd1, p);
    sb_pop(p);

    do_reset();
    sb_push("t2_down1_half", 1912);
    sb_push("t2_down1_period_clk", 2 * 1912 * PRE);
    strobe(8'h1C, 2'd3);
    sb_pop(dut.g_voice[0].u_voice.half_q);
    measure_period(8'h1C, 2'd3, p);
    sb_pop(p);

    do_reset();
    sb_push("t2_up2_half", 239);
    strobe(8'h1C, 2'd2);
    sb_pop(dut.g_voice[0].u_voice.half_q);

    // fill all voices back to back, then steal
    do_reset();
    sb_push("t3_fill_active", 4'b1111);
    sb_push("t3_fill_ptr", 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      code = fill_codes[i]; octave_shift = 2'd0; code_valid = 1'b1;
    end
    @(negedge clk);
    sb_pop(ch_active);
    sb_pop(dut.steal_ptr);
    sb_push("t3_steal_ptr", 1);
    sb_push("t3_steal_code", 8'h2C);
    sb_push("t3_steal_half", 1276);
    code = 8'h2C; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    sb_pop(dut.steal_ptr);
    sb_pop(dut.g_voice[0].u_voice.code_q);
    sb_pop(dut.g_voice[0].u_voice.half_q);

    sb_push("t3_steal2_ptr", 2);
    sb_push("t3_steal2_code", 8'h35);
    strobe(8'h35, 2'd0);
    sb_pop(dut.steal_ptr);
    sb_pop(dut.g_voice[1].u_voice.code_q);

    sb_push("t3_retrig_ptr", 2);
    sb_push("t3_retrig_v3_code", 8'h2D);
    strobe(8'h24, 2'd0);
    sb_pop(dut.steal_ptr);
    sb_pop(dut.g_voice[3].u_voice.code_q);

    // non-note codes are ignored
    sb_push("t4_f0_active", 4'b1111);
    sb_push("t4_f0_ptr", 2);
    strobe(8'hF0, 2'd0);
    sb_pop(ch_active);
    sb_pop(dut.steal_ptr);
    sb_push("t4_00_ptr", 2);
    sb_push("t4_00_v0_code", 8'h2C);
    strobe(8'h00, 2'd0);
    sb_pop(dut.steal_ptr);
    sb_pop(dut.g_voice[0].u_voice.code_q);

    // retrigger one clock before expiry, then on the expiry cycle itself
    do_reset();
    strobe(8'h15, 2'd0);
    sb_push("t5_first_ms_tick", 1);
    wait_ms_tick(ok);
    sb_pop(ok);
    repeat (MS_CLK - 1) @(negedge clk);
    code = 8'h15; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    sb_push("t5_ms_tick_period", 1);
    sb_push("t5_pre_active", 4'b0001);
    sb_push("t5_pre_hold", 2);
    sb_pop(dut.ms_tick);
    sb_pop(ch_active);
    sb_pop(dut.g_voice[0].u_voice.hold_q);
    sb_push("t5_same_ms_tick", 1);
    wait_ms_tick(ok);
    sb_pop(ok);
    code = 8'h15; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    sb_push("t5_same_active", 4'b0001);
    sb_push("t5_same_hold", 2);
    sb_pop(ch_active);
    sb_pop(dut.g_voice[0].u_voice.hold_q);
    sb_push("t5_late_expire", 1);
    cycles_until_idle(6000, n);
    sb_pop(int'(n >= 3 * MS_CLK / 2 && n <= 5 * MS_CLK / 2));

    // mute with two voices high, then unmuted mixer
    do_reset();
    strobe(8'h15, 2'd0);
    strobe(8'h1D, 2'd0);
    sb_push("t6_mute_speaker_hi", 0);
    sb_push("t6_mute_two_high", 1);
    sb_push("t6_mute_active", 4'b0011);
    run_window(5000, 1'b1, sp_hi, both_hi, bad);
    sb_pop(sp_hi);
    sb_pop(int'(both_hi > 0));
    sb_pop(ch_active);
    sb_push("t6_mix_mismatch_cycles", 0);
    sb_push("t6_mix_speaker_hi", 1);
    run_window(3000, 1'b0, sp_hi, both_hi, bad);
    sb_pop(bad);
    sb_pop(int'(sp_hi > 0));

    // reset in the middle of notes
    for (int i = 2; i < 4; i++) strobe(fill_codes[i], 2'd0);
    sb_push("t7_pre_ptr", 1);
    strobe(8'h2C, 2'd0);
    sb_pop(dut.steal_ptr);
    sb_push("t7_speaker_seen", 1);
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (speaker) begin
        ok = 1;
        break;
      end
    end
    sb_pop(ok);
    sb_push("t7_rst_speaker", 0);
    sb_push("t7_rst_active", 0);
    #2 rst_n = 1'b0;
    #1;
    sb_pop(speaker);
    sb_pop(ch_active);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_push("t7_post_ptr", 0);
    sb_push("t7_post_active", 0);
    @(negedge clk);
    sb_pop(dut.steal_ptr);
    sb_pop(ch_active);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
